// File: rtl/sched_pkg.sv
// Shared types for the hardware task scheduler: command opcodes, per-slot
// task state and the command-ready control states.
package sched_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ADD     = 3'd1,
    OP_REMOVE  = 3'd2,
    OP_BLOCK   = 3'd3,
    OP_UNBLOCK = 3'd4,
    OP_SETPRIO = 3'd5,
    OP_YIELD   = 3'd6
  } sched_op_t;

  typedef enum logic [1:0] {
    TS_FREE    = 2'd0,
    TS_READY   = 2'd1,
    TS_BLOCKED = 2'd2,
    TS_RUNNING = 2'd3
  } task_state_t;

  typedef enum logic {
    CTRL_RESET = 1'b0,
    CTRL_RUN   = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/sched_prio_select.sv
// Combinational arg-max over READY slots. Slots are rotated so that rr_ptr
// becomes position 0, then a binary comparator tree picks the highest
// priority; on equal priority the lower rotated position (earlier in the
// round-robin scan) wins.
module sched_prio_select
  import sched_pkg::*;
#(
  parameter int NUM_TASKS = 16,
  parameter int PRIO_W    = 8,
  localparam int TID_W    = $clog2(NUM_TASKS)
) (
  input  task_state_t       state [NUM_TASKS],
  input  logic [PRIO_W-1:0] prio  [NUM_TASKS],
  input  logic [TID_W-1:0]  rr_ptr,
  output logic              sel_valid,
  output logic [TID_W-1:0]  sel_tid,
  output logic [PRIO_W-1:0] sel_prio
);

  // Heap-ordered tree: node k combines children 2k and 2k+1; leaves at N..2N-1
  logic              node_v [1:2*NUM_TASKS-1];
  logic [TID_W-1:0]  node_t [1:2*NUM_TASKS-1];
  logic [PRIO_W-1:0] node_p [1:2*NUM_TASKS-1];

  // Rotate into the leaves, then reduce pairwise toward the root
  always_comb begin
    for (int unsigned k = 1; k < 2 * NUM_TASKS; k++) begin
      node_v[k] = 1'b0;
      node_t[k] = '0;
      node_p[k] = '0;
    end
    for (int unsigned i = 0; i < NUM_TASKS; i++) begin
      node_t[NUM_TASKS + i] = rr_ptr + TID_W'(i);
      node_v[NUM_TASKS + i] = (state[node_t[NUM_TASKS + i]] == TS_READY);
      node_p[NUM_TASKS + i] = prio[node_t[NUM_TASKS + i]];
    end
    for (int unsigned k = NUM_TASKS - 1; k >= 1; k--) begin
      if (node_v[2*k+1] && (!node_v[2*k] || (node_p[2*k+1] > node_p[2*k]))) begin
        node_v[k] = node_v[2*k+1];
        node_t[k] = node_t[2*k+1];
        node_p[k] = node_p[2*k+1];
      end else begin
        node_v[k] = node_v[2*k];
        node_t[k] = node_t[2*k];
        node_p[k] = node_p[2*k];
      end
    end
    sel_valid = node_v[1];
    sel_tid   = node_t[1];
    sel_prio  = node_p[1];
  end

endmodule

// File: rtl/hw_task_scheduler.sv
// Task table with command port, dispatch handshake and a registered
// highest-priority/round-robin queue head.
module hw_task_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_TASKS = 16,
  parameter int PRIO_W    = 8,
  localparam int TID_W    = $clog2(NUM_TASKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [TID_W-1:0]  cmd_tid,
  input  logic [PRIO_W-1:0] cmd_prio,
  input  logic              dispatch,
  output logic              head_valid,
  output logic [TID_W-1:0]  head_tid,
  output logic [PRIO_W-1:0] head_prio,
  output logic              running_valid,
  output logic [TID_W-1:0]  running_tid,
  output logic [TID_W:0]    ready_count,
  output logic              empty_flag,
  output logic              cmd_err
);

  ctrl_state_t       ctrl_q, ctrl_d;
  task_state_t       st_q [NUM_TASKS];
  task_state_t       st_d [NUM_TASKS];
  logic [PRIO_W-1:0] pr_q [NUM_TASKS];
  logic [PRIO_W-1:0] pr_d [NUM_TASKS];
  logic [TID_W-1:0]  rr_q, rr_d;
  logic              run_v_d;
  logic [TID_W-1:0]  run_t_d;
  logic              err_d, tbl_chg;
  logic              sel_v;
  logic [TID_W-1:0]  sel_t;
  logic [PRIO_W-1:0] sel_p;
  logic [TID_W:0]    cnt;
  sched_op_t         op;

  assign op = sched_op_t'(cmd_op);

  // Command-ready control state register
  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= CTRL_RESET;
    else     ctrl_q <= ctrl_d;
  end

  // Hold off commands for the first cycle after reset releases
  always_comb begin
    ctrl_d    = ctrl_q;
    cmd_ready = 1'b0;
    case (ctrl_q)
      CTRL_RESET: ctrl_d = CTRL_RUN;
      CTRL_RUN: begin
        ctrl_d    = CTRL_RUN;
        cmd_ready = 1'b1;
      end
      default: ctrl_d = CTRL_RESET;
    endcase
  end

  // Next table: dispatch applied first, then the command on the updated table
  always_comb begin
    st_d    = st_q;
    pr_d    = pr_q;
    rr_d    = rr_q;
    run_v_d = running_valid;
    run_t_d = running_tid;
    err_d   = 1'b0;
    tbl_chg = 1'b0;
    if (dispatch && head_valid) begin
      if (running_valid) st_d[running_tid] = TS_READY;
      st_d[head_tid] = TS_RUNNING;
      run_v_d = 1'b1;
      run_t_d = head_tid;
      rr_d    = head_tid + TID_W'(1);
      tbl_chg = 1'b1;
    end
    if (cmd_valid && cmd_ready) begin
      case (op)
        OP_ADD:
          if (st_d[cmd_tid] == TS_FREE) begin
            st_d[cmd_tid] = TS_READY;
            pr_d[cmd_tid] = cmd_prio;
            tbl_chg = 1'b1;
          end else err_d = 1'b1;
        OP_REMOVE:
          if (st_d[cmd_tid] != TS_FREE) begin
            if (st_d[cmd_tid] == TS_RUNNING) run_v_d = 1'b0;
            st_d[cmd_tid] = TS_FREE;
            tbl_chg = 1'b1;
          end else err_d = 1'b1;
        OP_BLOCK:
          if (st_d[cmd_tid] == TS_READY || st_d[cmd_tid] == TS_RUNNING) begin
            if (st_d[cmd_tid] == TS_RUNNING) run_v_d = 1'b0;
            st_d[cmd_tid] = TS_BLOCKED;
            tbl_chg = 1'b1;
          end else err_d = 1'b1;
        OP_UNBLOCK:
          if (st_d[cmd_tid] == TS_BLOCKED) begin
            st_d[cmd_tid] = TS_READY;
            tbl_chg = 1'b1;
          end else err_d = 1'b1;
        OP_SETPRIO:
          if (st_d[cmd_tid] != TS_FREE) begin
            pr_d[cmd_tid] = cmd_prio;
            tbl_chg = 1'b1;
          end else err_d = 1'b1;
        OP_YIELD:
          if (run_v_d) begin
            st_d[run_t_d] = TS_READY;
            run_v_d = 1'b0;
            tbl_chg = 1'b1;
          end else err_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Count READY slots in the current table
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < NUM_TASKS; i++)
      if (st_q[i] == TS_READY) cnt = cnt + (TID_W+1)'(1);
  end

  sched_prio_select #(
    .NUM_TASKS(NUM_TASKS),
    .PRIO_W   (PRIO_W)
  ) u_sel (
    .state    (st_q),
    .prio     (pr_q),
    .rr_ptr   (rr_q),
    .sel_valid(sel_v),
    .sel_tid  (sel_t),
    .sel_prio (sel_p)
  );

  // Table, running task and registered head/count stage; the head is
  // suppressed for the cycle following any table change since it was
  // selected from the pre-change table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_TASKS; i++) begin
        st_q[i] <= TS_FREE;
        pr_q[i] <= '0;
      end
      rr_q          <= '0;
      running_valid <= 1'b0;
      running_tid   <= '0;
      cmd_err       <= 1'b0;
      head_valid    <= 1'b0;
      head_tid      <= '0;
      head_prio     <= '0;
      ready_count   <= '0;
      empty_flag    <= 1'b1;
    end else begin
      st_q          <= st_d;
      pr_q          <= pr_d;
      rr_q          <= rr_d;
      running_valid <= run_v_d;
      running_tid   <= run_t_d;
      cmd_err       <= err_d;
      head_valid    <= sel_v & ~tbl_chg;
      head_tid      <= sel_t;
      head_prio     <= sel_p;
      ready_count   <= cnt;
      empty_flag    <= (cnt == '0);
    end
  end

endmodule

// File: tb/tb_hw_task_scheduler.sv
// Self-checking bench for hw_task_scheduler: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_hw_task_scheduler;
  import sched_pkg::*;

  localparam int N  = 16;
  localparam int PW = 8;
  localparam int TW = 4;

  localparam int S_FREE = 0, S_READY = 1, S_BLOCKED = 2, S_RUNNING = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          dispatch = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [TW-1:0] cmd_tid = '0;
  logic [PW-1:0] cmd_prio = '0;
  logic          cmd_ready, head_valid, running_valid, empty_flag, cmd_err;
  logic [TW-1:0] head_tid, running_tid;
  logic [PW-1:0] head_prio;
  logic [TW:0]   ready_count;

  always #5 clk = ~clk;

  hw_task_scheduler #(.NUM_TASKS(N), .PRIO_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_tid      (cmd_tid),
    .cmd_prio     (cmd_prio),
    .dispatch     (dispatch),
    .head_valid   (head_valid),
    .head_tid     (head_tid),
    .head_prio    (head_prio),
    .running_valid(running_valid),
    .running_tid  (running_tid),
    .ready_count  (ready_count),
    .empty_flag   (empty_flag),
    .cmd_err      (cmd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: task table plus expected registered outputs
  int m_st [N];
  int m_pr [N];
  bit m_rv;
  int m_rt, m_rr;
  bit e_rdy, e_hv, e_err, e_empty;
  int e_ht, e_hp, e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Highest priority READY task; first one met scanning upward from rr wins ties
  task automatic best(output bit any, output int t, output int p);
    any = 0; t = 0; p = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (m_st[i] == S_READY && m_pr[i] > p) begin
        any = 1; t = i; p = m_pr[i];
      end
    end
  endtask

  task automatic model_edge();
    bit any, chg, err;
    int bt, bp, cnt, t;
    best(any, bt, bp);
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == S_READY) cnt++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_st[i] = S_FREE; m_pr[i] = 0; end
      m_rv = 0; m_rt = 0; m_rr = 0;
      e_rdy = 0; e_hv = 0; e_ht = 0; e_hp = 0; e_cnt = 0; e_empty = 1; e_err = 0;
    end else begin
      chg = 0; err = 0;
      if (dispatch && e_hv) begin
        if (m_rv) m_st[m_rt] = S_READY;
        m_st[e_ht] = S_RUNNING;
        m_rv = 1; m_rt = e_ht; m_rr = (e_ht + 1) % N;
        chg = 1;
      end
      if (cmd_valid && e_rdy) begin
        t = int'(cmd_tid);
        case (cmd_op)
          OP_ADD:     if (m_st[t] == S_FREE) begin m_st[t] = S_READY; m_pr[t] = int'(cmd_prio); chg = 1; end
                      else err = 1;
          OP_REMOVE:  if (m_st[t] != S_FREE) begin
                        if (m_st[t] == S_RUNNING) m_rv = 0;
                        m_st[t] = S_FREE; chg = 1;
                      end else err = 1;
          OP_BLOCK:   if (m_st[t] == S_READY || m_st[t] == S_RUNNING) begin
                        if (m_st[t] == S_RUNNING) m_rv = 0;
                        m_st[t] = S_BLOCKED; chg = 1;
                      end else err = 1;
          OP_UNBLOCK: if (m_st[t] == S_BLOCKED) begin m_st[t] = S_READY; chg = 1; end
                      else err = 1;
          OP_SETPRIO: if (m_st[t] != S_FREE) begin m_pr[t] = int'(cmd_prio); chg = 1; end
                      else err = 1;
          OP_YIELD:   if (m_rv) begin m_st[m_rt] = S_READY; m_rv = 0; chg = 1; end
                      else err = 1;
          default: ;
        endcase
      end
      e_hv = chg ? 1'b0 : any;
      e_ht = bt; e_hp = bp;
      e_cnt = cnt; e_empty = (cnt == 0); e_err = err;
      e_rdy = 1;
    end
  endtask

  task automatic check_outputs();
    chk("cmd_ready", cmd_ready, e_rdy);
    chk("cmd_err", cmd_err, e_err);
    chk("head_valid", head_valid, e_hv);
    if (e_hv) begin
      chk("head_tid", head_tid, e_ht);
      chk("head_prio", head_prio, e_hp);
    end
    chk("running_valid", running_valid, m_rv);
    if (m_rv) chk("running_tid", running_tid, m_rt);
    chk("ready_count", ready_count, e_cnt);
    chk("empty_flag", empty_flag, e_empty);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_cmd(input sched_op_t op, input int tid, input int p);
    cmd_valid = 1'b1; cmd_op = op; cmd_tid = tid[TW-1:0]; cmd_prio = p[PW-1:0];
    tick();
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("ready_low_after_rst", cmd_ready, 0);
    tick();
  endtask

  task automatic wait_head();
    for (int i = 0; i < 20 && !head_valid; i++) tick();
    chk("head_wait", head_valid, 1);
  endtask

  initial begin
    int exp_seq [4];
    exp_seq = '{1, 2, 5, 1};

    // Reset values
    rst = 1'b1;
    tick(); tick();
    chk("rst_empty", empty_flag, 1);
    chk("rst_head_valid", head_valid, 0);
    chk("rst_head_tid", head_tid, 0);
    chk("rst_head_prio", head_prio, 0);
    chk("rst_running", running_valid, 0);
    chk("rst_count", ready_count, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    chk("ready_low_after_rst", cmd_ready, 0);
    tick();
    chk("ready_high", cmd_ready, 1);

    // Basic priority
    do_cmd(OP_ADD, 3, 5);
    do_cmd(OP_ADD, 7, 9);
    chk("stale_head", head_valid, 0);
    tick();
    chk("basic_tid", head_tid, 7);
    chk("basic_prio", head_prio, 9);
    chk("basic_count", ready_count, 2);
    chk("basic_empty", empty_flag, 0);

    // Round-robin among equal priorities
    do_reset();
    do_cmd(OP_ADD, 1, 4);
    do_cmd(OP_ADD, 2, 4);
    do_cmd(OP_ADD, 5, 4);
    for (int k = 0; k < 4; k++) begin
      wait_head();
      chk("fair_seq", head_tid, exp_seq[k]);
      dispatch = 1'b1;
      tick();
      dispatch = 1'b0;
      chk("fair_running", running_tid, exp_seq[k]);
      do_cmd(OP_YIELD, 0, 0);
    end

    // Priority changes via block/unblock/setprio
    do_reset();
    do_cmd(OP_ADD, 2, 3);
    do_cmd(OP_ADD, 6, 8);
    do_cmd(OP_BLOCK, 6, 0);
    tick();
    chk("block_head", head_tid, 2);
    do_cmd(OP_UNBLOCK, 6, 0);
    tick();
    chk("unblock_head", head_tid, 6);
    do_cmd(OP_SETPRIO, 2, 10);
    tick();
    chk("setprio_head", head_tid, 2);
    chk("setprio_prio", head_prio, 10);

    // Illegal commands
    do_reset();
    do_cmd(OP_ADD, 4, 1);
    do_cmd(OP_ADD, 4, 7);
    chk("dup_add_err", cmd_err, 1);
    tick();
    chk("dup_add_err_pulse", cmd_err, 0);
    chk("dup_add_prio_kept", head_prio, 1);
    chk("dup_add_count", ready_count, 1);
    do_cmd(OP_YIELD, 0, 0);
    chk("yield_idle_err", cmd_err, 1);
    do_cmd(OP_UNBLOCK, 4, 0);
    chk("unblock_ready_err", cmd_err, 1);

    // Same-cycle dispatch and BLOCK of the head task
    do_cmd(OP_ADD, 5, 20);
    wait_head();
    chk("pre_disp_head", head_tid, 5);
    dispatch = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_BLOCK; cmd_tid = 4'd5; cmd_prio = '0;
    tick();
    dispatch = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP;
    chk("disp_block_running", running_valid, 0);
    chk("disp_block_err", cmd_err, 0);
    tick();
    chk("disp_block_count", ready_count, 1);
    do_cmd(OP_UNBLOCK, 5, 0);
    chk("disp_block_was_blocked", cmd_err, 0);

    // Reset mid-stream with ten READY tasks
    do_reset();
    for (int i = 0; i < 10; i++) do_cmd(OP_ADD, i, i % 3);
    tick();
    chk("ten_ready", ready_count, 10);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_tid = 4'd12; cmd_prio = 8'd7;
    tick();
    chk("midrst_empty", empty_flag, 1);
    chk("midrst_head_valid", head_valid, 0);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_count", ready_count, 0);
    rst = 1'b0;
    chk("midrst_ready_hold", cmd_ready, 0);
    tick();
    tick();
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    tick();
    chk("post_rst_add_count", ready_count, 1);
    chk("post_rst_add_head", head_tid, 12);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 249) == 0);
      dispatch  = ($urandom_range(0, 3) == 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = ($urandom_range(0, 2) == 0) ? 3'(OP_ADD) : 3'($urandom_range(0, 6));
      cmd_tid   = TW'($urandom_range(0, N - 1));
      cmd_prio  = ($urandom_range(0, 9) == 0) ? 8'd255 : PW'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; dispatch = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
